sync_bus_capture: RTL
=====================

# sync_bus_capture

Destination-domain consumer of the strobe synchronizer's `synchronized_bus`. Runs entirely in clock domain B. Watches the synchronized bus for value changes and qualifies each new value as stable for a programmable number of cycles. Queues each qualified value in a small first-word-fall-through FIFO with a valid/ready output. This gives domain-B logic one discrete, back-pressurable event per settled bus update.

## Interface
- `WIDTH`, 4, bus width; matches the synchronizer's bus width.
- `STABLE_CYCLES`, 2, consecutive matching samples required after a change is first detected (legal range ≥1).
- `DEPTH`, 4, FIFO entries (power of two, ≥2).

Ports:
- `clk_b` in 1: domain-B clock.
- `rst_b` in 1: reset; one clock; reset is synchronous and active-high.
- `bus_in` in WIDTH: driven from the synchronizer's `synchronized_bus`.
- `out_data` in/out: out, WIDTH; FIFO head, valid only when `out_valid`=1.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head this cycle.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; set when a qualified value meets a full FIFO with no pop that cycle.

## Operation
- Registers:
  - `last_val`: last committed value; reset 0.
  - `cand`: candidate value; reset 0.
  - `cnt`: qualify counter, $clog2(STABLE_CYCLES)+1 bits; reset 0.
  - FIFO storage, read pointer, write pointer and count.
- FSM states: IDLE (reset state), QUALIFY, PUSH.
  - IDLE: if `bus_in`≠`last_val`, then `cand`←`bus_in`, `cnt`←0, go to QUALIFY. Otherwise stay in IDLE.
  - QUALIFY, when `bus_in`==`cand`: if `cnt`==STABLE_CYCLES−1, go to PUSH; else `cnt`++.
  - QUALIFY, when `bus_in`==`last_val`: glitch rejected; go to IDLE with no push.
  - QUALIFY, otherwise (new value): `cand`←`bus_in`, `cnt`←0, stay in QUALIFY.
  - PUSH (exactly one cycle): enqueue `cand` (full handling below), `last_val`←`cand`, go to IDLE.
- FIFO pop: occurs on a cycle with `out_valid`&&`out_ready`. `out_data` shows the new head on the following cycle.
- Push accept rule: the push is accepted if not full, or if a pop occurs the same cycle. In that case `level` is unchanged.
- Push rejected (full, no pop): `overflow`←1. Payload handling depends on configuration (below). `last_val` still updates, so the value is not re-detected.
- `overflow` clears only on reset.
- `out_ready` while empty: ignored; pointers unchanged.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0.
  - `out_data`=0: storage is cleared on reset.
  - FSM in IDLE.
- Reset mid-operation: in-flight qualification is abandoned and the FIFO is emptied. After release, any nonzero `bus_in` is detected as a change because `last_val`=0.
- Latency: a new value sampled at edge E0 (in IDLE) and held stable is handled as follows.
  - It enters PUSH after edge E0+STABLE_CYCLES.
  - It is written at edge E0+STABLE_CYCLES+1.
  - With an empty FIFO, `out_valid`=1 and `out_data`=value in the cycle after that edge. This is 3 edges of qualification plus 1 write edge for the default STABLE_CYCLES=2.
- Back-to-back events: IDLE re-checks on the cycle after PUSH. Minimum spacing between pushes is STABLE_CYCLES+2 cycles.
- All outputs are registered; no combinational path from `bus_in` or `out_ready` to any output.

## Configuration
- `SYNC_CAPTURE_DROP_OLDEST_EN`
  - Defined: a rejected push overwrites the oldest entry. The head advances by one and the new value is written at the tail. `level` stays at DEPTH and `overflow` is set.
  - Undefined (default): the new value is discarded, FIFO contents are unchanged, and `overflow` is set.

## Test plan
- Reset and first change: hold `rst_b`=1 for 3 cycles, release with `bus_in`=4'b0000, then drive 4'b1010 at edge E0 and hold. Expect:
  - `out_valid`=0 until after edge E0+3.
  - Then `out_valid`=1, `out_data`=4'b1010, `level`=1.
- Glitch rejection: from `last_val`=4'b1010, drive 4'b0110 for 1 cycle, then back to 4'b1010. Expect no push and `level` unchanged.
- Candidate restart: drive 4'b0001 for 1 cycle, then 4'b0011 held. Expect a single entry 4'b0011, with latency counted from the 4'b0011 sample.
- Full and overflow, default build: hold `out_ready`=0 and push 5 distinct values (1,2,3,4,5). Expect:
  - `level`=4 and `overflow`=1.
  - Draining yields 1,2,3,4.
  - With `SYNC_CAPTURE_DROP_OLDEST_EN` defined, draining yields 2,3,4,5.
- Simultaneous push/pop while full: with `level`=4 and `out_ready`=1 in the PUSH cycle, expect `overflow` to remain 0, `level`=4, and the new value to be present at the tail.
- Reset mid-QUALIFY: assert `rst_b` one cycle after a change is detected. Expect `level`=0, `out_valid`=0 and `overflow`=0. After release, the held nonzero `bus_in` is re-qualified and pushed once.

Source files
------------

// File: rtl/sync_bus_capture.sv
// Domain-B bus change qualifier feeding a small FWFT FIFO with valid/ready output.
// Optional SYNC_CAPTURE_DROP_OLDEST_EN: a push into a full FIFO evicts the oldest entry instead of being discarded.
module sync_bus_capture #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int DEPTH         = 4
) (
    input  logic                     clk_b,
    input  logic                     rst_b,
    input  logic [WIDTH-1:0]         bus_in,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_PUSH    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   last_val_r;
    logic [WIDTH-1:0]   cand_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               load_cand_s;
    logic               inc_cnt_s;
    logic               push_s;

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [LVL_W-1:0]   count_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_valid_r;
    logic               overflow_r;

    logic               pop_s;
    logic               full_s;
    logic               reject_s;
    logic               wr_en_s;
    logic               rd_adv_s;
    logic [PTR_W-1:0]   rd_ptr_s;
    logic [PTR_W-1:0]   wr_ptr_s;
    logic [LVL_W-1:0]   count_s;
    logic [WIDTH-1:0]   head_s;

    // FSM state register
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus_in != last_val_r) state_s = ST_QUALIFY;
                else                      state_s = ST_IDLE;
            end
            ST_QUALIFY: begin
                if (bus_in == cand_r) begin
                    if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) state_s = ST_PUSH;
                    else                                     state_s = ST_QUALIFY;
                end else if (bus_in == last_val_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_QUALIFY;
                end
            end
            ST_PUSH: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        load_cand_s = 1'b0;
        inc_cnt_s   = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus_in != last_val_r) load_cand_s = 1'b1;
                else                      load_cand_s = 1'b0;
            end
            ST_QUALIFY: begin
                if (bus_in == cand_r) begin
                    if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) inc_cnt_s = 1'b0;
                    else                                     inc_cnt_s = 1'b1;
                end else if (bus_in == last_val_r) begin
                    load_cand_s = 1'b0;
                end else begin
                    load_cand_s = 1'b1;
                end
            end
            ST_PUSH: push_s = 1'b1;
            default: push_s = 1'b0;
        endcase
    end

    // Candidate, qualify counter and committed value
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            last_val_r <= '0;
            cand_r     <= '0;
            cnt_r      <= '0;
        end else begin
            if (load_cand_s) begin
                cand_r <= bus_in;
                cnt_r  <= '0;
            end else if (inc_cnt_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (push_s) begin
                last_val_r <= cand_r;
            end
        end
    end

    // FIFO next-state: a rejected push either drops the new value or evicts the head
    always_comb begin
        pop_s    = (count_r != LVL_W'(0)) && out_ready;
        full_s   = (count_r == LVL_W'(DEPTH));
        reject_s = push_s && full_s && !pop_s;
`ifdef SYNC_CAPTURE_DROP_OLDEST_EN
        wr_en_s  = push_s;
        rd_adv_s = pop_s || reject_s;
`else
        wr_en_s  = push_s && !reject_s;
        rd_adv_s = pop_s;
`endif
        rd_ptr_s = rd_ptr_r + PTR_W'(rd_adv_s);
        wr_ptr_s = wr_ptr_r + PTR_W'(wr_en_s);
        count_s  = count_r + LVL_W'(wr_en_s) - LVL_W'(rd_adv_s);
        if (wr_en_s && (wr_ptr_r == rd_ptr_s)) head_s = cand_r;
        else                                    head_s = mem_r[rd_ptr_s];
    end

    // FIFO storage, pointers and registered outputs
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) mem_r[wr_ptr_r] <= cand_r;
            rd_ptr_r    <= rd_ptr_s;
            wr_ptr_r    <= wr_ptr_s;
            count_r     <= count_s;
            out_data_r  <= head_s;
            out_valid_r <= (count_s != LVL_W'(0));
            overflow_r  <= overflow_r | reject_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign level     = count_r;
    assign overflow  = overflow_r;

endmodule
